// File: rtl/triangle_fifo.sv
// Triangle queue between the transform stage and the rasterizer control FSM; 1-cycle registered read.
// Latency: write visible next cycle, pop strobe at N gives data at N+1; full/empty block strobes and set sticky flags.
module triangle_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   fifo_w,
    input  logic [2:0][1:0][9:0]   triangle_in,
    output logic                   fifo_full,
    input  logic                   fifo_r,
    output logic [2:0][1:0][9:0]   triangle_data,
    output logic                   fifo_empty,
    output logic [ADDR_W:0]        count,
    input  logic                   flush,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [2:0][1:0][9:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [ADDR_W:0]      r_count;
    logic [2:0][1:0][9:0] r_data;
    logic                 r_overflow;
    logic                 r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;
    logic w_wr_drop;
    logic w_rd_drop;

    // Flags come straight off the registered count, so they cannot glitch.
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_wr_en   = fifo_w && !w_full  && !flush && !Reset;
    assign w_rd_en   = fifo_r && !w_empty && !flush && !Reset;
    assign w_wr_drop = fifo_w && w_full   && !flush;
    assign w_rd_drop = fifo_r && w_empty  && !flush;

    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= triangle_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            // Memory, head word and sticky flags survive a flush.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_drop) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign fifo_full     = w_full;
    assign fifo_empty    = w_empty;
    assign count         = r_count;
    assign triangle_data = r_data;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule
